// File: rtl/spi_frame_rx_if.sv
// Signal bundle for the SPI frame receiver: serial link pins in, decoded frame
// results and the channel register bank out.
interface spi_frame_rx_if #(
  parameter int CH_NUM = 8
);
  logic                  sclk;
  logic                  din;
  logic                  sync_n;
  logic [12*CH_NUM-1:0]  ch_data;
  logic                  frame_valid;
  logic [2:0]            frame_chan;
  logic [11:0]           frame_data;
  logic                  frame_err;
  logic [15:0]           frame_cnt;
  logic                  busy;

  // Link driver / result consumer side
  modport master (
    output sclk, din, sync_n,
    input  ch_data, frame_valid, frame_chan, frame_data, frame_err, frame_cnt, busy
  );

  // Receiver side
  modport slave (
    input  sclk, din, sync_n,
    output ch_data, frame_valid, frame_chan, frame_data, frame_err, frame_cnt, busy
  );
endinterface

// File: rtl/spi_frame_rx.sv
// SPI frame receiver for the 16-bit DAC link (sync_n framed, sclk idles high,
// MSB first). Oversamples the link on clk_core, decodes channel/data and keeps
// an 8-entry channel register bank.
module spi_frame_rx #(
  parameter int SPI_LEN     = 16,
  parameter int SYNC_STAGES = 2,
  parameter int CH_NUM      = 8
) (
  input  logic          clk_core,
  input  logic          rst,
  spi_frame_rx_if.slave bus
);

  localparam int CW = $clog2(SPI_LEN + 2);
  localparam logic [CW-1:0] BITS_FULL = CW'(SPI_LEN);
  localparam logic [CW-1:0] BITS_MAX  = CW'(SPI_LEN + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  // Synchronizers, edge history and start-up arming
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] din_sync_q, din_sync_d;
  logic [SYNC_STAGES-1:0] sync_n_sync_q, sync_n_sync_d;
  logic [SYNC_STAGES-1:0] settle_q, settle_d;
  logic                   sclk_hist_q, sclk_hist_d;
  logic                   sync_n_hist_q, sync_n_hist_d;
  logic                   armed_q, armed_d;

  // Frame state
  logic [1:0]             state_q, state_d;
  logic [SPI_LEN-1:0]     shreg_q, shreg_d;
  logic [CW-1:0]          bitcnt_q, bitcnt_d;
  logic                   busy_q, busy_d;

  // Results and channel bank
  logic [12*CH_NUM-1:0]   ch_data_q, ch_data_d;
  logic                   frame_valid_q, frame_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic [2:0]             frame_chan_q, frame_chan_d;
  logic [11:0]            frame_data_q, frame_data_d;
  logic [15:0]            frame_cnt_q, frame_cnt_d;

  logic sclk_s, din_s, sync_n_s, settled;
  logic sclk_fall, sync_fall, sync_rise, good;
  logic [2:0]  rx_chan;
  logic [11:0] rx_data;

  assign sclk_s   = sclk_sync_q[SYNC_STAGES-1];
  assign din_s    = din_sync_q[SYNC_STAGES-1];
  assign sync_n_s = sync_n_sync_q[SYNC_STAGES-1];
  assign settled  = settle_q[SYNC_STAGES-1];

  // Edges are seen one cycle after the synchronized level changes. A sync_n
  // fall is only honoured once sync_n has been seen high after reset, so a
  // line already low when reset releases cannot start a frame.
  assign sclk_fall = sclk_hist_q & ~sclk_s;
  assign sync_fall = sync_n_hist_q & ~sync_n_s & armed_q;
  assign sync_rise = ~sync_n_hist_q & sync_n_s;

  assign rx_chan = shreg_q[14:12];
  assign rx_data = shreg_q[11:0];
  assign good    = (bitcnt_q == BITS_FULL) && !shreg_q[SPI_LEN-1];

  // Input synchronizer chains, edge history and arming after reset
  always_comb begin
    sclk_sync_d   = {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
    din_sync_d    = {din_sync_q[SYNC_STAGES-2:0], bus.din};
    sync_n_sync_d = {sync_n_sync_q[SYNC_STAGES-2:0], bus.sync_n};
    settle_d      = {settle_q[SYNC_STAGES-2:0], 1'b1};
    sclk_hist_d   = sclk_s;
    sync_n_hist_d = sync_n_s;
    armed_d       = armed_q | (settled & sync_n_s);
  end

  // Frame FSM: shift on sclk falls, judge the frame one cycle after sync_n rises
  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    bitcnt_d      = bitcnt_q;
    busy_d        = busy_q;
    ch_data_d     = ch_data_q;
    frame_chan_d  = frame_chan_q;
    frame_data_d  = frame_data_q;
    frame_cnt_d   = frame_cnt_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (sync_fall) begin
          state_d  = ST_SHIFT;
          shreg_d  = '0;
          bitcnt_d = '0;
          busy_d   = 1'b1;
        end
      end
      ST_SHIFT: begin
        // sync_n rising wins over an sclk fall in the same cycle
        if (sync_rise) begin
          state_d = ST_CHECK;
        end else if (sclk_fall) begin
          shreg_d = {shreg_q[SPI_LEN-2:0], din_s};
          if (bitcnt_q != BITS_MAX) begin
            bitcnt_d = bitcnt_q + 1'b1;
          end
        end
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        if (good) begin
          ch_data_d[12*rx_chan +: 12] = rx_data;
          frame_chan_d  = rx_chan;
          frame_data_d  = rx_data;
          frame_cnt_d   = frame_cnt_q + 16'd1;
          frame_valid_d = 1'b1;
        end else begin
          frame_err_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers; synchronizers preset high to match the idle lines
  always_ff @(posedge clk_core or posedge rst) begin
    if (rst) begin
      sclk_sync_q   <= '1;
      din_sync_q    <= '1;
      sync_n_sync_q <= '1;
      settle_q      <= '0;
      sclk_hist_q   <= 1'b1;
      sync_n_hist_q <= 1'b1;
      armed_q       <= 1'b0;
      state_q       <= ST_IDLE;
      shreg_q       <= '0;
      bitcnt_q      <= '0;
      busy_q        <= 1'b0;
      ch_data_q     <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_chan_q  <= '0;
      frame_data_q  <= '0;
      frame_cnt_q   <= '0;
    end else begin
      sclk_sync_q   <= sclk_sync_d;
      din_sync_q    <= din_sync_d;
      sync_n_sync_q <= sync_n_sync_d;
      settle_q      <= settle_d;
      sclk_hist_q   <= sclk_hist_d;
      sync_n_hist_q <= sync_n_hist_d;
      armed_q       <= armed_d;
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      bitcnt_q      <= bitcnt_d;
      busy_q        <= busy_d;
      ch_data_q     <= ch_data_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      frame_chan_q  <= frame_chan_d;
      frame_data_q  <= frame_data_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign bus.ch_data     = ch_data_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.frame_chan  = frame_chan_q;
  assign bus.frame_data  = frame_data_q;
  assign bus.frame_cnt   = frame_cnt_q;
  assign bus.busy        = busy_q;

endmodule
